// File: rtl/lap_pkg.sv
// lap_pkg: types and constants shared by the lap recall block.
//   DEPTH_DEFAULT - default number of stored laps
//   digit_t       - one BCD digit (not range-checked; stored verbatim)
//   lap_entry_t   - one stored lap, dig3 most significant
//   state_t       - display/recall state machine encoding
package lap_pkg;

  localparam int DEPTH_DEFAULT = 8;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    digit_t dig3;
    digit_t dig2;
    digit_t dig1;
    digit_t dig0;
  } lap_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RECALL = 1'b1
  } state_t;

endpackage

// File: rtl/lap_mem.sv
// lap_mem: DEPTH x 16-bit lap register file.
//   clk   - clock
//   we    - write enable, writes wdata at waddr on the rising edge
//   waddr - write slot
//   wdata - lap entry to store
//   raddr - read slot
//   rdata - combinational read of raddr
// Contents are not reset; the owner masks stale slots with its lap count.
module lap_mem
  import lap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  lap_entry_t       wdata,
  input  logic [PTR_W-1:0] raddr,
  output lap_entry_t       rdata
);

  lap_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_recall.sv
// lap_recall: stopwatch lap store with recall of older laps.
//   clk           - clock, rising edge
//   rst           - asynchronous reset, active low
//   clr           - synchronous clear of all stored laps
//   lap_store     - pulse: store {d3,d2,d1,d0} as the newest lap
//   d0..d3        - running time digits, d0 least significant
//   recall_next   - pulse: enter recall, or step to the next-older lap
//   recall_exit   - pulse: leave recall
//   d4..d7        - displayed lap digits, d4 least significant
//   lap_idx       - age of displayed lap, 0 = newest
//   lap_cnt       - number of valid laps, 0..DEPTH
//   recall_active - high while recalling
// Same-cycle priority: lap_store > clr > recall_exit > recall_next.
// All outputs are registered: an event at edge N shows after edge N.
module lap_recall
  import lap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             lap_store,
  input  logic [3:0]       d0,
  input  logic [3:0]       d1,
  input  logic [3:0]       d2,
  input  logic [3:0]       d3,
  input  logic             recall_next,
  input  logic             recall_exit,
  output logic [3:0]       d4,
  output logic [3:0]       d5,
  output logic [3:0]       d6,
  output logic [3:0]       d7,
  output logic [PTR_W-1:0] lap_idx,
  output logic [CNT_W-1:0] lap_cnt,
  output logic             recall_active
);

  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  lap_entry_t       disp;

  lap_entry_t       wr_entry;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] rd_idx;
  logic [PTR_W-1:0] rd_addr;
  lap_entry_t       rd_data;

  assign wr_entry = '{dig3: d3, dig2: d2, dig1: d1, dig0: d0};
  // A store that coincides with clr lands in slot 0 of the emptied buffer.
  assign wr_addr  = clr ? '0 : wr_ptr;

  // Index of the lap to display after this edge when no store or clear
  // happens. The buffer is not written in that case, so reading it now
  // gives exactly what the display must hold next cycle.
  always_comb begin
    rd_idx = '0;
    if (state == RECALL && !clr && !recall_exit) begin
      if (recall_next) begin
        rd_idx = ({1'b0, lap_idx} == lap_cnt - ONE_CNT) ? '0 : lap_idx + ONE_PTR;
      end else begin
        rd_idx = lap_idx;
      end
    end
  end

  // Slot of age rd_idx; modulo arithmetic is free since DEPTH is a power of two.
  assign rd_addr = wr_ptr - ONE_PTR - rd_idx;

  lap_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (lap_store),
    .waddr (wr_addr),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      recall_active <= 1'b0;
      wr_ptr        <= '0;
      lap_cnt       <= '0;
      lap_idx       <= '0;
      disp          <= '0;
    end else if (lap_store) begin
      state         <= IDLE;
      recall_active <= 1'b0;
      lap_idx       <= '0;
      disp          <= wr_entry;
      if (clr) begin
        wr_ptr  <= ONE_PTR;
        lap_cnt <= ONE_CNT;
      end else begin
        wr_ptr <= wr_ptr + ONE_PTR;
        if (lap_cnt != DEPTH_CNT) begin
          lap_cnt <= lap_cnt + ONE_CNT;
        end
      end
    end else if (clr) begin
      state         <= IDLE;
      recall_active <= 1'b0;
      wr_ptr        <= '0;
      lap_cnt       <= '0;
      lap_idx       <= '0;
      disp          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (recall_next && lap_cnt != '0) begin
            state         <= RECALL;
            recall_active <= 1'b1;
          end
        end
        RECALL: begin
          if (recall_exit) begin
            state         <= IDLE;
            recall_active <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          recall_active <= 1'b0;
        end
      endcase
      lap_idx <= rd_idx;
      disp    <= (lap_cnt == '0) ? '0 : rd_data;
    end
  end

  assign d4 = disp.dig0;
  assign d5 = disp.dig1;
  assign d6 = disp.dig2;
  assign d7 = disp.dig3;

endmodule

// File: tb/tb_lap_recall.sv
module tb_lap_recall;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       lap_store;
  logic [3:0] d0, d1, d2, d3;
  logic       recall_next;
  logic       recall_exit;
  logic [3:0] d4, d5, d6, d7;
  logic [2:0] lap_idx;
  logic [3:0] lap_cnt;
  logic       recall_active;

  typedef struct {
    string       tag;
    logic [15:0] disp;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic        act;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  lap_recall #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .lap_store     (lap_store),
    .d0            (d0),
    .d1            (d1),
    .d2            (d2),
    .d3            (d3),
    .recall_next   (recall_next),
    .recall_exit   (recall_exit),
    .d4            (d4),
    .d5            (d5),
    .d6            (d6),
    .d7            (d7),
    .lap_idx       (lap_idx),
    .lap_cnt       (lap_cnt),
    .recall_active (recall_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [15:0] e_disp,
                            input int e_idx, input int e_cnt, input logic e_act);
    exp_t e;
    e.tag  = tag;
    e.disp = e_disp;
    e.idx  = 3'(e_idx);
    e.cnt  = 4'(e_cnt);
    e.act  = e_act;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [15:0] obs;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=nonzero");
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {d7, d6, d5, d4};
      $display("txn %s: disp=%h idx=%0d cnt=%0d act=%0b", e.tag, obs, lap_idx, lap_cnt, recall_active);
      checks++;
      assert (obs === e.disp) else begin
        failures++;
        $error("FAIL %s disp observed=%h expected=%h", e.tag, obs, e.disp);
      end
      checks++;
      assert (lap_idx === e.idx) else begin
        failures++;
        $error("FAIL %s lap_idx observed=%0d expected=%0d", e.tag, lap_idx, e.idx);
      end
      checks++;
      assert (lap_cnt === e.cnt) else begin
        failures++;
        $error("FAIL %s lap_cnt observed=%0d expected=%0d", e.tag, lap_cnt, e.cnt);
      end
      checks++;
      assert (recall_active === e.act) else begin
        failures++;
        $error("FAIL %s recall_active observed=%0b expected=%0b", e.tag, recall_active, e.act);
      end
    end
  endtask

  // Drive one cycle of pulses, queue the expected result, check it after the edge.
  task automatic cyc(input logic st, input logic cl, input logic nx, input logic ex,
                     input logic [15:0] din, input string tag, input logic [15:0] e_disp,
                     input int e_idx, input int e_cnt, input logic e_act);
    @(negedge clk);
    lap_store   = st;
    clr         = cl;
    recall_next = nx;
    recall_exit = ex;
    {d3, d2, d1, d0} = din;
    expect_out(tag, e_disp, e_idx, e_cnt, e_act);
    @(posedge clk);
    #1;
    lap_store   = 1'b0;
    clr         = 1'b0;
    recall_next = 1'b0;
    recall_exit = 1'b0;
    check_out();
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    lap_store = 1'b0;
    recall_next = 1'b0;
    recall_exit = 1'b0;
    {d3, d2, d1, d0} = 16'h0000;

    // Reset state
    #3;
    expect_out("reset", 16'h0000, 0, 0, 1'b0);
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // Three laps, newest shown in IDLE
    cyc(1, 0, 0, 0, 16'h0012, "store_0012", 16'h0012, 0, 1, 1'b0);
    cyc(1, 0, 0, 0, 16'h0034, "store_0034", 16'h0034, 0, 2, 1'b0);
    cyc(1, 0, 0, 0, 16'h0056, "store_0056", 16'h0056, 0, 3, 1'b0);
    cyc(0, 0, 0, 0, 16'h9999, "idle_hold", 16'h0056, 0, 3, 1'b0);

    // Recall walk with wrap, then exit
    cyc(0, 0, 1, 0, 16'h0000, "recall_idx0", 16'h0056, 0, 3, 1'b1);
    cyc(0, 0, 1, 0, 16'h0000, "recall_idx1", 16'h0034, 1, 3, 1'b1);
    cyc(0, 0, 1, 0, 16'h0000, "recall_idx2", 16'h0012, 2, 3, 1'b1);
    cyc(0, 0, 1, 0, 16'h0000, "recall_wrap", 16'h0056, 0, 3, 1'b1);
    cyc(0, 0, 0, 0, 16'h0000, "recall_hold", 16'h0056, 0, 3, 1'b1);
    cyc(0, 0, 0, 1, 16'h0000, "recall_exit", 16'h0056, 0, 3, 1'b0);

    // Store while recalling at idx1
    cyc(0, 0, 1, 0, 16'h0000, "rs_idx0", 16'h0056, 0, 3, 1'b1);
    cyc(0, 0, 1, 0, 16'h0000, "rs_idx1", 16'h0034, 1, 3, 1'b1);
    cyc(1, 0, 0, 0, 16'h0777, "store_in_recall", 16'h0777, 0, 4, 1'b0);

    // Store and clear together, then clear alone, then ignored recall
    cyc(1, 1, 0, 0, 16'h0450, "store_clr", 16'h0450, 0, 1, 1'b0);
    cyc(0, 1, 0, 0, 16'h0000, "clr_only", 16'h0000, 0, 0, 1'b0);
    cyc(0, 0, 1, 0, 16'h0000, "recall_empty", 16'h0000, 0, 0, 1'b0);

    // Nine laps into eight slots: oldest overwritten, count saturates
    for (int i = 1; i <= 9; i++) begin
      cyc(1, 0, 0, 0, 16'(i), "store9", 16'(i), 0, (i > 8) ? 8 : i, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 0, 16'h0000, "recall9", 16'(9 - k), k, 8, 1'b1);
    end
    cyc(0, 0, 1, 0, 16'h0000, "recall9_wrap", 16'h0009, 0, 8, 1'b1);

    // Non-BCD digits kept verbatim; priority checks
    cyc(1, 0, 1, 1, 16'hF9AB, "store_raw", 16'hF9AB, 0, 8, 1'b0);
    cyc(0, 0, 1, 0, 16'h0000, "pr_idx0", 16'hF9AB, 0, 8, 1'b1);
    cyc(0, 0, 1, 0, 16'h0000, "pr_idx1", 16'h0009, 1, 8, 1'b1);
    cyc(0, 0, 1, 1, 16'h0000, "exit_over_next", 16'hF9AB, 0, 8, 1'b0);
    cyc(0, 0, 1, 0, 16'h0000, "pr2_idx0", 16'hF9AB, 0, 8, 1'b1);
    cyc(0, 1, 1, 1, 16'h0000, "clr_over_exit", 16'h0000, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a recall
    cyc(1, 0, 0, 0, 16'h0012, "ar_store1", 16'h0012, 0, 1, 1'b0);
    cyc(1, 0, 0, 0, 16'h0034, "ar_store2", 16'h0034, 0, 2, 1'b0);
    cyc(0, 0, 1, 0, 16'h0000, "ar_idx0", 16'h0034, 0, 2, 1'b1);
    cyc(0, 0, 1, 0, 16'h0000, "ar_idx1", 16'h0012, 1, 2, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 16'h0000, 0, 0, 1'b0);
    check_out();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 1, 0, 16'h0000, "post_reset_next", 16'h0000, 0, 0, 1'b0);
    cyc(1, 0, 0, 0, 16'h0005, "post_reset_store", 16'h0005, 0, 1, 1'b0);
    cyc(0, 0, 1, 0, 16'h0000, "post_reset_recall", 16'h0005, 0, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lap_recall.md
LAP_RECALL -- requirements
Module: lap_recall

Interface
REQ-001 Parameter: DEPTH, default 8, number of stored lap entries (power of two, 2..16).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 clr  input  1  synchronous clear of all stored laps, active-high.
REQ-005 lap_store  input  1  one-cycle pulse (already debounced); capture current time as a new lap.
REQ-006 d0,d1,d2,d3  input  4 each  running-time BCD digits, d0 least significant.
REQ-007 recall_next  input  1  one-cycle pulse; enter recall or step to the next-older lap.
REQ-008 recall_exit  input  1  one-cycle pulse; leave recall mode.
REQ-009 d4,d5,d6,d7  output  4 each  displayed lap BCD digits, d4 least significant.
REQ-010 lap_idx  output  $clog2(DEPTH)  age of displayed lap; 0 = newest.
REQ-011 lap_cnt  output  $clog2(DEPTH)+1  number of valid stored laps, 0..DEPTH.
REQ-012 recall_active  output  1  high while in RECALL state.

Function
REQ-013 Storage: circular buffer of DEPTH entries; each entry holds 4 digits; write pointer wr_ptr.
REQ-014 lap_store: write {d3,d2,d1,d0} at wr_ptr; wr_ptr increments mod DEPTH; lap_cnt increments, saturating at DEPTH.
REQ-015 Full buffer: lap_store overwrites the oldest entry; lap_cnt stays DEPTH.
REQ-016 States: IDLE, RECALL.
REQ-017 IDLE: d4..d7 show the newest entry; all zeros when lap_cnt = 0; lap_idx = 0.
REQ-018 IDLE -> RECALL: recall_next with lap_cnt > 0; displayed entry = newest (lap_idx 0).
REQ-019 recall_next in IDLE with lap_cnt = 0: ignored, stay IDLE.
REQ-020 RECALL + recall_next: lap_idx increments; at lap_idx = lap_cnt-1 it wraps to 0.
REQ-021 RECALL + recall_exit: -> IDLE, lap_idx = 0.
REQ-022 RECALL + lap_store: entry written per REQ-014, state -> IDLE, display shows new entry.
REQ-023 Displayed slot = (wr_ptr - 1 - lap_idx) mod DEPTH.
REQ-024 Priority, same cycle: lap_store > clr > recall_exit > recall_next.
REQ-025 lap_store with clr, same cycle: buffer cleared, then new lap written; lap_cnt = 1, IDLE.
REQ-026 clr alone: lap_cnt = 0, wr_ptr = 0, IDLE, d4..d7 = 0 on the next cycle.
REQ-027 Latency: all outputs registered; an event at edge N is visible after edge N (one clock).
REQ-028 Input digits are not range-checked; stored and replayed verbatim.

Reset
REQ-029 rst low: immediately, independent of clk: d4..d7 = 0, lap_idx = 0, lap_cnt = 0, recall_active = 0, wr_ptr = 0, state IDLE.
REQ-030 Stored entry contents need not be reset; lap_cnt = 0 masks them.
REQ-031 Reset asserted mid-recall aborts recall; first pulse after release is handled normally.

Structure
REQ-032 Shared package lap_pkg: DEPTH default, 4-bit digit type, lap entry struct of 4 digits, state enum {IDLE, RECALL}.
REQ-033 One sub-module lap_mem: DEPTH x 16-bit register file, one synchronous write port, one combinational read port.
REQ-034 State machine, pointers and output registers reside in lap_recall.

Verification
REQ-035 Reset, then store laps 0012, 0034, 0056 -> IDLE shows 0056, lap_cnt 3.
REQ-036 From REQ-035: recall_next x4 -> display 0056(idx0), 0034(idx1), 0012(idx2), 0056(idx0); recall_exit -> IDLE, 0056.
REQ-037 Store 9 laps 0001..0009 (DEPTH 8) -> lap_cnt 8; recall to idx7 shows 0002; 0001 gone.
REQ-038 In RECALL at idx1, pulse lap_store with d=0777 -> next cycle IDLE, display 0777, lap_cnt +1.
REQ-039 lap_store and clr same cycle with d=0450 -> lap_cnt 1, display 0450; clr alone -> display 0000, lap_cnt 0.
REQ-040 Assert rst asynchronously mid-cycle during RECALL -> outputs zero before next clk edge; recall_next afterward ignored (lap_cnt 0).
